// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for an 8-digit seven-segment display: steps through the digits at a
// programmable rate, blanks leading zeros and swaps in new values only between frames.
module seven_seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        load,
    input  logic [31:0] value,
    input  logic [7:0]  dp_mask,
    output logic [3:0]  num,
    output logic [2:0]  sel,
    output logic        dp,
    output logic        blank,
    output logic        frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [2:0]    idx;
    logic [31:0]   active_val;
    logic [31:0]   pend_val;
    logic [7:0]    active_dp;
    logic [7:0]    pend_dp;
    logic          pend_valid;

    logic          tick;
    logic          boundary;
    logic          blank_int;
    logic [7:0]    hi_zero;
    logic [3:0]    cur_nib;

    assign tick     = enable && (prescaler == PRE_LAST);
    assign boundary = tick && (idx == 3'd7);

    // hi_zero[k]: nibbles k..7 of the active value are all zero
    always_comb begin
        hi_zero = '0;
        for (int k = 0; k < 8; k++) begin
            hi_zero[k] = ((active_val >> (4 * k)) == 32'd0);
        end
    end

    assign cur_nib   = active_val[{idx, 2'b00} +: 4];
    assign blank_int = !enable || (BLANK_LZ && (idx != 3'd0) && hi_zero[idx]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (!enable) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
            idx       <= idx + 3'd1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // A load coinciding with the frame boundary bypasses the pending buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_val <= '0;
            active_dp  <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                active_val <= value;
                active_dp  <= dp_mask;
            end else if (pend_valid) begin
                active_val <= pend_val;
                active_dp  <= pend_dp;
            end
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_val   <= value;
            pend_dp    <= dp_mask;
            pend_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num        <= '0;
            sel        <= '0;
            dp         <= 1'b0;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            num        <= cur_nib;
            sel        <= idx;
            dp         <= active_dp[idx] && !blank_int;
            blank      <= blank_int;
            frame_done <= boundary;
        end
    end

endmodule
